// File: rtl/sample_serializer.sv
// sample_serializer: shifts a parallel sample out as an SPI-style frame.
// Define SERIALIZER_DUAL_CHANNEL_EN to send {s_i, s_q}; the default sends s_i only.
module sample_serializer #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] s_q,
    output logic             sclk,
    output logic             sdata,
    output logic             cs_n,
    output logic             busy
);

`ifdef SERIALIZER_DUAL_CHANNEL_EN
    localparam int N = 2 * WIDTH;
`else
    localparam int N = WIDTH;
`endif
    localparam int BW      = $clog2(2 * WIDTH + 1);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_LEN = GAP * 2 * DIV;
    localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAPWAIT
    } state_t;

    logic [N-1:0] frame;

`ifdef SERIALIZER_DUAL_CHANNEL_EN
    assign frame = {s_i, s_q};
`else
    logic unused_s_q;
    assign frame      = s_i;
    assign unused_s_q = ^s_q;
`endif

    state_t        state_q, state_d;
    logic [N-1:0]  sreg_q,  sreg_d;
    logic [DW-1:0] div_q,   div_d;
    logic [BW-1:0] bit_q,   bit_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic          sclk_q,  sclk_d;
    logic          sdata_q, sdata_d;
    logic          cs_n_q,  cs_n_d;

    // Next-state: load on handshake, shift on sclk falls, then idle gap.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        cs_n_d  = cs_n_q;
        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d = SHIFT;
                    sreg_d  = frame;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    sdata_d = frame[N-1];
                    cs_n_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        if (bit_q == BIT_LAST) begin
                            sclk_d  = 1'b0;
                            sdata_d = 1'b0;
                            cs_n_d  = 1'b1;
                            gap_d   = '0;
                            state_d = (GAP == 0) ? IDLE : GAPWAIT;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            sreg_d  = sreg_q << 1;
                            sdata_d = sreg_d[N-1];
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAPWAIT: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign s_ready = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign sclk    = sclk_q;
    assign sdata   = sdata_q;
    assign cs_n    = cs_n_q;

endmodule
